// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch requester (I)
//   and a data requester (D). It grants one port at a time, alternates
//   between ports when both keep requesting, and waits for MemAck with a
//   timeout. A timeout completes the access with read data 32'hDEAD_BEEF
//   and Err set.
//
// Parameters
//   TIMEOUT  maximum BUSY cycles without MemAck (1..255)
//   PRI_D    port that wins ties: 1 = data port, 0 = instruction port
//
// Ports
//   clk, RegReset                  clock, asynchronous active-low reset
//   IReq, IAddr                    fetch request and address
//   IRdata, IDone                  fetch read data and completion pulse
//   DReq, DWe, DAddr, DWdata       data request, store flag, address, store data
//   DRdata, DDone                  load data and completion pulse
//   StallF, StallM                 requester waiting (combinational)
//   Err                            the last completion was a timeout
//   MemReq, MemWe, MemAddr, MemWdata   memory request side
//   MemRdata, MemAck               memory response side
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter bit          PRI_D   = 1'b1
) (
  input  logic        clk,
  input  logic        RegReset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IDone,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DDone,
  output logic        StallF,
  output logic        StallM,
  output logic        Err,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  input  logic        MemAck
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D,
    S_DONE_I,
    S_DONE_D
  } state_t;

  localparam logic [7:0]  CNT_LAST     = 8'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_rst_sync;
  logic [7:0]  r_cnt;
  logic        r_last_win;   // 1 = data port completed last, 0 = fetch port
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_irdata;
  logic [31:0] r_drdata;
  logic        r_err;

  logic        w_run;
  logic        w_busy;
  logic        w_timeout;
  logic        w_pick_d;

  // Reset release is re-timed through two flops so the FSM only starts
  // moving once the deassertion is safely synchronous to clk.
  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge RegReset) begin
    if (!RegReset) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run     = r_rst_sync[1];
  assign w_busy    = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
  assign w_timeout = w_busy && !MemAck && (r_cnt == CNT_LAST);
  // Under contention the priority winner is granted unless it also won the
  // previous transaction, in which case the other port goes first.
  assign w_pick_d  = (r_last_win == PRI_D) ? !PRI_D : PRI_D;

  // NOTE: the next state gets a default before the case so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (IReq && DReq) w_state_nxt = w_pick_d ? S_BUSY_D : S_BUSY_I;
        else if (IReq)    w_state_nxt = S_BUSY_I;
        else if (DReq)    w_state_nxt = S_BUSY_D;
      end
      S_BUSY_I: if (MemAck || w_timeout) w_state_nxt = S_DONE_I;
      S_BUSY_D: if (MemAck || w_timeout) w_state_nxt = S_DONE_D;
      S_DONE_I,
      S_DONE_D: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RegReset) begin
    if (!RegReset) r_state <= S_IDLE;
    else if (w_run) r_state <= w_state_nxt;
  end

  // NOTE: the latched request and read-data registers are reset too, because
  // the read-data and Err outputs must read zero while in reset.
  always_ff @(posedge clk or negedge RegReset) begin
    if (!RegReset) begin
      r_cnt      <= '0;
      r_last_win <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_irdata   <= '0;
      r_drdata   <= '0;
      r_err      <= 1'b0;
    end else if (w_run) begin
      case (r_state)
        S_IDLE: begin
          // Requester inputs are captured only on the grant edge.
          if (w_state_nxt == S_BUSY_I) begin
            r_addr  <= IAddr;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
          end else if (w_state_nxt == S_BUSY_D) begin
            r_addr  <= DAddr;
            r_we    <= DWe;
            r_wdata <= DWdata;
            r_cnt   <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          // MemAck takes precedence over a timeout in the same cycle.
          if (MemAck) begin
            if (r_state == S_BUSY_I) r_irdata <= MemRdata;
            else                     r_drdata <= MemRdata;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            if (r_state == S_BUSY_I) r_irdata <= TIMEOUT_DATA;
            else                     r_drdata <= TIMEOUT_DATA;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE_I: r_last_win <= 1'b0;
        S_DONE_D: r_last_win <= 1'b1;
        default:  ;
      endcase
    end
  end

  assign MemReq   = w_busy;
  assign MemWe    = (r_state == S_BUSY_D) && r_we;
  assign MemAddr  = w_busy ? r_addr  : '0;
  assign MemWdata = w_busy ? r_wdata : '0;

  assign IDone  = (r_state == S_DONE_I);
  assign DDone  = (r_state == S_DONE_D);
  assign IRdata = r_irdata;
  assign DRdata = r_drdata;
  assign Err    = r_err;

  // Stalls are gated by reset so every output reads zero while in reset.
  assign StallF = RegReset && IReq && !IDone;
  assign StallM = RegReset && DReq && !DDone;

endmodule
